// File: rtl/ysyx_23060059_rr_rd_arbiter.sv
// Two-master round-robin AXI4 read arbiter (A = IFU, B = LSU).
// A grant is held from the AR handshake to the rlast beat. The returned
// beat count and ID are checked against the granted request, and any
// violation raises a sticky error flag.
module ysyx_23060059_rr_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4
) (
  input  logic              clock,
  input  logic              reset,
  // master A
  input  logic              arvalidA,
  output logic              arreadyA,
  input  logic [ADDR_W-1:0] araddrA,
  input  logic [ID_W-1:0]   aridA,
  input  logic [7:0]        arlenA,
  input  logic [2:0]        arsizeA,
  input  logic [1:0]        arburstA,
  output logic              rvalidA,
  input  logic              rreadyA,
  output logic [DATA_W-1:0] rdataA,
  output logic [1:0]        rrespA,
  output logic [ID_W-1:0]   ridA,
  output logic              rlastA,
  // master B
  input  logic              arvalidB,
  output logic              arreadyB,
  input  logic [ADDR_W-1:0] araddrB,
  input  logic [ID_W-1:0]   aridB,
  input  logic [7:0]        arlenB,
  input  logic [2:0]        arsizeB,
  input  logic [1:0]        arburstB,
  output logic              rvalidB,
  input  logic              rreadyB,
  output logic [DATA_W-1:0] rdataB,
  output logic [1:0]        rrespB,
  output logic [ID_W-1:0]   ridB,
  output logic              rlastB,
  // downstream
  output logic              arvalid,
  input  logic              arready,
  output logic [ADDR_W-1:0] araddr,
  output logic [ID_W-1:0]   arid,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  input  logic              rvalid,
  output logic              rready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic [ID_W-1:0]   rid,
  input  logic              rlast,
  // status
  output logic [1:0]        grant_o,
  output logic              err_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        grant_q, grant_d;   // one-hot {B,A}
  logic              prio_q, prio_d;     // 0: A preferred, 1: B preferred
  logic [7:0]        beat_cnt_q, beat_cnt_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic              err_q, err_d;

  logic              sel_b;
  logic              sel_arvalid;
  logic [7:0]        sel_arlen;
  logic [ID_W-1:0]   sel_arid;
  logic              sel_rready;

  // Request fields of whichever master currently owns the grant
  always_comb begin
    sel_b       = grant_q[1];
    sel_arvalid = sel_b ? arvalidB : arvalidA;
    sel_arlen   = sel_b ? arlenB   : arlenA;
    sel_arid    = sel_b ? aridB    : aridA;
    sel_rready  = sel_b ? rreadyB  : rreadyA;
  end

  // State and bookkeeping registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      prio_q     <= 1'b0;
      beat_cnt_q <= '0;
      id_q       <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      prio_q     <= prio_d;
      beat_cnt_q <= beat_cnt_d;
      id_q       <= id_d;
      err_q      <= err_d;
    end
  end

  // Arbitration, burst tracking and protocol checking
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    prio_d     = prio_q;
    beat_cnt_d = beat_cnt_q;
    id_d       = id_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (rvalid) err_d = 1'b1;
        if (arvalidA || arvalidB) begin
          state_d = S_ADDR;
          if (arvalidA && arvalidB) grant_d = prio_q ? 2'b10 : 2'b01;
          else                      grant_d = arvalidA ? 2'b01 : 2'b10;
        end
      end
      S_ADDR: begin
        if (rvalid) err_d = 1'b1;
        if (!sel_arvalid) begin
          state_d = S_IDLE;
          grant_d = '0;
        end else if (arready) begin
          state_d    = S_DATA;
          beat_cnt_d = sel_arlen;
          id_d       = sel_arid;
        end
      end
      S_DATA: begin
        if (rvalid && sel_rready) begin
          if (rid != id_q) err_d = 1'b1;
          if (rlast) begin
            if (beat_cnt_q != 8'd0) err_d = 1'b1;
            state_d = S_IDLE;
            grant_d = '0;
            prio_d  = ~sel_b;
          end else if (beat_cnt_q == 8'd0) begin
            // Overrun: flag it and hold the counter until rlast arrives.
            err_d = 1'b1;
          end else begin
            beat_cnt_d = beat_cnt_q - 8'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Output routing: only the granted master ever sees non-zero values
  always_comb begin
    grant_o  = grant_q;
    err_o    = err_q;
    arvalid  = 1'b0;
    araddr   = '0;
    arid     = '0;
    arlen    = '0;
    arsize   = '0;
    arburst  = '0;
    arreadyA = 1'b0;
    arreadyB = 1'b0;
    rready   = 1'b0;
    rvalidA  = 1'b0;
    rdataA   = '0;
    rrespA   = '0;
    ridA     = '0;
    rlastA   = 1'b0;
    rvalidB  = 1'b0;
    rdataB   = '0;
    rrespB   = '0;
    ridB     = '0;
    rlastB   = 1'b0;
    case (state_q)
      S_ADDR: begin
        arvalid = sel_arvalid;
        arid    = sel_arid;
        arlen   = sel_arlen;
        if (sel_b) begin
          araddr   = araddrB;
          arsize   = arsizeB;
          arburst  = arburstB;
          arreadyB = arready;
        end else begin
          araddr   = araddrA;
          arsize   = arsizeA;
          arburst  = arburstA;
          arreadyA = arready;
        end
      end
      S_DATA: begin
        rready = sel_rready;
        if (sel_b) begin
          rvalidB = rvalid;
          rdataB  = rdata;
          rrespB  = rresp;
          ridB    = rid;
          rlastB  = rlast;
        end else begin
          rvalidA = rvalid;
          rdataA  = rdata;
          rrespA  = rresp;
          ridA    = rid;
          rlastA  = rlast;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: doc/ysyx_23060059_rr_rd_arbiter.md
Name: ysyx_23060059_rr_rd_arbiter

Overview:
Two-master, burst-aware, round-robin AXI4 read arbiter. It shares the single core-side AXI read port between master A (IFU) and master B (LSU). A grant is held from the AR handshake through the R beat carrying rlast, and priority alternates after every completed burst so neither master starves. The block also checks the returned beat count and ID against the granted request and reports violations through a sticky error flag.

Parameters:
ADDR_W, 32, address width
DATA_W, 64, read data width
ID_W, 4, AXI ID width

Ports:
clock  in  1  single clock
reset  in  1  asynchronous, active-low reset
arvalidA / arvalidB  in  1 each  master read request
arreadyA / arreadyB  out  1 each  per-master AR ready
araddrA / araddrB  in  ADDR_W each  master AR address
aridA / aridB  in  ID_W each  master AR ID
arlenA / arlenB  in  8 each  master burst length minus 1
arsizeA / arsizeB  in  3 each  master AR beat size
arburstA / arburstB  in  2 each  master AR burst type
rvalidA / rvalidB  out  1 each  routed R valid
rreadyA / rreadyB  in  1 each  master R ready
rdataA / rdataB  out  DATA_W each  routed R data
rrespA / rrespB  out  2 each  routed R response
ridA / ridB  out  ID_W each  routed R ID
rlastA / rlastB  out  1 each  routed R last
arvalid  out  1  downstream AR valid
arready  in  1  downstream AR ready
araddr  out  ADDR_W  downstream AR address
arid  out  ID_W  downstream AR ID
arlen  out  8  downstream AR length
arsize  out  3  downstream AR size
arburst  out  2  downstream AR burst
rvalid  in  1  downstream R valid
rready  out  1  downstream R ready
rdata  in  DATA_W  downstream R data
rresp  in  2  downstream R response
rid  in  ID_W  downstream R ID
rlast  in  1  downstream R last
grant_o  out  2  one-hot current owner ({B,A}); 00 when idle
err_o  out  1  sticky protocol error

Behaviour:
- Reset (reset=0, asynchronous):
  - state←IDLE, grant←00, prio←A, beat_cnt←0, id_q←0, err_o←0.
  - Every downstream and per-master output is driven 0 while reset is low and in IDLE.
- State IDLE:
  - No downstream traffic.
  - If exactly one arvalidX=1, grant that master.
  - If both are 1, grant the master named by prio.
  - Granting registers the grant and moves to ADDR.
  - Arbitration latency is exactly 1 cycle: downstream arvalid rises the cycle after the request is first seen.
- State ADDR:
  - Downstream AR payload and arvalid are driven combinationally from the granted master.
  - arreadyX of the granted master = arready.
- ADDR transitions:
  - On arvalid&&arready: beat_cnt←arlen and id_q←arid of the granted master; go to DATA.
  - If the granted master drops arvalid before arready: return to IDLE, clear grant, leave prio unchanged.
- State DATA:
  - The granted master's rvalid, rdata, rresp, rid and rlast = downstream values.
  - rready = the granted master's rready.
  - The non-granted master sees all R outputs at 0.
  - Downstream AR is 0; both arreadyX = 0.
- Per R handshake (rvalid&&rready):
  - If rlast=0: beat_cnt decrements.
  - If rlast=1: go to IDLE, grant←00, prio←the non-granted master.
  - A new request can be granted on the following cycle, so back-to-back bursts are separated by one idle cycle.
- err_o is set, and held until reset, on any of:
  - rlast=1 on a handshake while beat_cnt≠0;
  - rlast=0 on a handshake while beat_cnt=0;
  - rid≠id_q on any handshake.
  Errors do not alter sequencing: rlast alone ends the burst.
- Non-granted outputs are 0 in every state. The non-granted master's request stays pending and is served next.
- A downstream rvalid outside DATA is ignored (rready=0) and sets err_o.

Test Plan:
- Single A request (araddr=0x8000_0000, arlen=0), arready=1 → downstream arvalid high on cycle 2, grant_o=01; one R beat with rlast=1 routed only to A; IDLE afterwards with prio=B.
- arvalidA and arvalidB both asserted continuously, each arlen=3 → bursts alternate A,B,A,B; each burst is 4 beats with rlast on the 4th; the ungranted master sees rvalid=0 throughout.
- arready held 0 for 5 cycles while A is granted, and B requests meanwhile → grant stays 01 and arreadyB=0; after the A burst completes, B is granted.
- arlen=1 but downstream asserts rlast on beat 1 → err_o=1 and stays 1; the burst ends and the next request is served normally.
- Downstream returns rid=0x3 when id_q=0x5 → err_o=1.
- reset driven low mid-DATA (beat 2 of 4) → outputs 0 asynchronously in the same cycle; after release, state is IDLE with grant_o=00 and err_o=0.
